// File: rtl/branch_resolve_bht.sv
// Branch/jump resolution with a 2-bit counter BHT, registered redirect/flush on mispredict.
// Optional BRANCH_STATS_EN adds saturating branch and mispredict counters.
module branch_resolve_bht #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [5:0]      branch,
    input  logic            jump,
    input  logic [3:0]      ALUFlags,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            PCNextSrc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    logic [1:0]       bht [BHT_DEPTH];
    logic             live;
    logic             taken;
    logic             mis;
    logic [5:0]       cond;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt;

    // Instructions arriving while a redirect is visible are wrong-path.
    assign live = ex_valid & ~redirect_valid;

    always_comb begin
        cond    = 6'b0;
        cond[5] = ALUFlags[2];                  // beq
        cond[4] = ~ALUFlags[2];                 // bne
        cond[3] = ALUFlags[3] ^ ALUFlags[0];    // blt
        cond[2] = ~(ALUFlags[3] ^ ALUFlags[0]); // bge
        cond[1] = ~ALUFlags[1];                 // bltu
        cond[0] = ALUFlags[1];                  // bgeu
    end

    assign taken     = live & ((|(branch & cond)) | jump);
    assign mis       = live & (taken ^ ex_pred_taken);
    assign PCNextSrc = taken;

    assign if_idx     = if_pc[IDX_W+1:2];
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign pred_taken = if_valid & bht[if_idx][1];

    always_comb begin
        ctr_cur = bht[ex_idx];
        ctr_nxt = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mis;
            if (mis) redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
            // Jump-only instructions never train; fetch reads the pre-update value.
            if (live && (|branch)) bht[ex_idx] <= ctr_nxt;
        end
    end

    assign flush = redirect_valid;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (live && ((|branch) || jump) && (stat_branches != 32'hFFFF_FFFF))
                stat_branches <= stat_branches + 32'd1;
            if (mis && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomized + directed bench for branch_resolve_bht; redirects checked through a scoreboard queue.
module tb_branch_resolve_bht;
    localparam int XLEN  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_valid = 1'b0;
    logic [XLEN-1:0] if_pc = '0;
    logic            pred_taken;
    logic            ex_valid = 1'b0;
    logic [XLEN-1:0] ex_pc = '0;
    logic [5:0]      branch = '0;
    logic            jump = 1'b0;
    logic [3:0]      ALUFlags = '0;
    logic            ex_pred_taken = 1'b0;
    logic [XLEN-1:0] ex_target = '0;
    logic            PCNextSrc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_resolve_bht #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .branch(branch), .jump(jump),
        .ALUFlags(ALUFlags), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .PCNextSrc(PCNextSrc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks = 0;
    int errors = 0;

    // Reference state: counters as plain integers 0..3, redirect-visible flag.
    int          m_bht [DEPTH];
    bit          m_redir = 1'b0;
    int unsigned m_br = 0;
    int unsigned m_mis = 0;

    typedef struct {
        int              cyc;
        logic [XLEN-1:0] pc;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit resolve(input logic [5:0] br, input logic j, input logic [3:0] f);
        bit n, z, c, v, t;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        t = j;
        if (br[5] && z)        t = 1;
        if (br[4] && !z)       t = 1;
        if (br[3] && (n != v)) t = 1;
        if (br[2] && (n == v)) t = 1;
        if (br[1] && !c)       t = 1;
        if (br[0] && c)        t = 1;
        return t;
    endfunction

    task automatic step(input bit rn, input bit iv, input logic [XLEN-1:0] ipc,
                        input bit ev, input logic [XLEN-1:0] epc, input logic [5:0] br,
                        input bit j, input logic [3:0] fl, input bit ep,
                        input logic [XLEN-1:0] tgt);
        bit live, tk, mis, exp_pred;
        int ii, ei;
        @(negedge clk);
        rst_n = rn; if_valid = iv; if_pc = ipc; ex_valid = ev; ex_pc = epc;
        branch = br; jump = j; ALUFlags = fl; ex_pred_taken = ep; ex_target = tgt;
        #1;
        ii       = int'((ipc >> 2) % DEPTH);
        ei       = int'((epc >> 2) % DEPTH);
        exp_pred = iv && (m_bht[ii] >= 2);
        live     = ev && !m_redir;
        tk       = live && resolve(br, j, fl);
        mis      = live && (tk != ep);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, exp_pred});
        check("PCNextSrc", {31'b0, PCNextSrc}, {31'b0, tk});
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mis);
`endif
        if (!rn) begin
            foreach (m_bht[k]) m_bht[k] = 1;
            m_redir = 0; m_br = 0; m_mis = 0;
        end else begin
            if (mis) sbq.push_back('{edges + 1, tk ? tgt : epc + 32'd4});
            if (live && (|br)) m_bht[ei] = tk ? ((m_bht[ei] == 3) ? 3 : m_bht[ei] + 1)
                                              : ((m_bht[ei] == 0) ? 0 : m_bht[ei] - 1);
            if (live && ((|br) || j) && m_br != 32'hFFFF_FFFF) m_br++;
            if (mis && m_mis != 32'hFFFF_FFFF) m_mis++;
            m_redir = mis;
        end
    endtask

    task automatic idle(input logic [XLEN-1:0] ipc);
        step(1, 1, ipc, 0, 0, 6'b0, 0, 4'b0, 0, 0);
    endtask

    // Monitor: every redirect must match the head of the scoreboard at the expected cycle.
    logic [XLEN-1:0] hold_pc = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            check("flush_eq_redirect", {31'b0, flush}, {31'b0, redirect_valid});
            if (!rst_n) begin
                hold_pc = '0;
                check("reset_redirect_valid", {31'b0, redirect_valid}, 32'd0);
                check("reset_redirect_pc", redirect_pc, 32'd0);
            end else if (redirect_valid) begin
                if (sbq.size() > 0 && sbq[0].cyc == edges) begin
                    e = sbq.pop_front();
                    hold_pc = e.pc;
                    check("redirect_pc", redirect_pc, e.pc);
                end else begin
                    checks++; errors++;
                    $display("FAIL unexpected_redirect: got redirect_valid=1 pc=%h expected none (t=%0t)",
                             redirect_pc, $time);
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].cyc <= edges) begin
                    e = sbq.pop_front();
                    checks++; errors++;
                    $display("FAIL missing_redirect: got redirect_valid=0 expected pc=%h (t=%0t)", e.pc, $time);
                end
                check("redirect_pc_hold", redirect_pc, hold_pc);
            end
        end
    end

    initial begin
        foreach (m_bht[k]) m_bht[k] = 1;
        // Reset, then sweep every index: all weakly not-taken.
        step(0, 0, 0, 0, 0, 6'b0, 0, 4'b0, 0, 0);
        step(0, 0, 0, 0, 0, 6'b0, 0, 4'b0, 0, 0);
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

        // beq taken, predicted not-taken: redirect to target, counter 1->2.
        step(1, 1, 32'h100, 1, 32'h100, 6'b100000, 0, 4'b0100, 0, 32'h80);
        idle(32'h100);
        idle(32'h100);
        // Saturate with correctly predicted taken branches, then one not-taken.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h100, 1, 32'h100, 6'b100000, 0, 4'b0100, 1, 32'h80);
        step(1, 1, 32'h100, 1, 32'h100, 6'b100000, 0, 4'b0000, 1, 32'h80);
        idle(32'h100);
        idle(32'h100);

        // bne at the top of memory: not-taken fallthrough wraps to 0; next ex is squashed.
        step(1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 6'b010000, 0, 4'b0100, 1, 32'h40);
        step(1, 1, 32'hFFFF_FFFC, 1, 32'h200, 6'b100000, 0, 4'b0100, 0, 32'h300);
        idle(32'h200);
        // bne taken with pred 0, target 0.
        step(1, 1, 32'h0, 1, 32'hFFFF_FFFC, 6'b010000, 0, 4'b0000, 0, 32'h0);
        idle(32'hFFFF_FFFC);

        // jal predicted taken: no redirect, no training.
        step(1, 1, 32'h300, 1, 32'h300, 6'b0, 1, 4'b0000, 1, 32'h500);
        idle(32'h300);
        // blt N=1 V=1 is not taken; predicted taken -> fallthrough redirect.
        step(1, 1, 32'h400, 1, 32'h400, 6'b001000, 0, 4'b1001, 1, 32'h800);
        idle(32'h400);
        // jal predicted not-taken must mispredict.
        step(1, 1, 32'h500, 1, 32'h500, 6'b0, 1, 4'b0000, 0, 32'h900);
        idle(32'h500);

        // Mispredict then reset on the following edge; then mispredict coinciding with reset.
        step(1, 1, 32'h100, 1, 32'h100, 6'b100000, 0, 4'b0100, 0, 32'h80);
        step(0, 1, 32'h100, 0, 0, 6'b0, 0, 4'b0, 0, 0);
        idle(32'h100);
        step(1, 1, 32'h100, 1, 32'h100, 6'b100000, 0, 4'b0100, 1, 32'h80);
        step(0, 1, 32'h100, 1, 32'h104, 6'b100000, 0, 4'b0100, 0, 32'h80);
        for (int i = 0; i < DEPTH; i++) idle(32'(i * 4));

        // Random traffic with PC aliasing across the table.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] br;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)       br = 6'(1 << r);
            else if (r == 8) br = 6'($urandom);
            else             br = 6'b0;
            step(($urandom_range(0, 299) != 0), 1'($urandom), 32'($urandom_range(0, 255) << 2),
                 ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255) << 2), br,
                 ($urandom_range(0, 5) == 0), 4'($urandom), 1'($urandom), $urandom);
        end

        idle(0);
        idle(0);
        idle(0);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
